// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and sizes for the round-robin mux-select arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters, the consumer and the arbiter.
// The master side is the arbiter; the slave side is everything around it.
interface rr_sel_arbiter_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  sel_t             sel;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic             timeout_flag;

  modport master (
    input  req,
    input  done,
    output sel,
    output gnt,
    output gnt_valid,
    output timeout_flag
  );

  modport slave (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  gnt_valid,
    input  timeout_flag
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Rotated first-one search: finds the first asserted request starting at
// ptr and wrapping modulo N_REQ, so the source after the last winner is
// considered first.
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             found,
  output sel_t             idx
);

  sel_t cand;

  // Scan from the furthest offset back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = sel_t'(ptr + sel_t'(k));
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux. A winner
// owns the mux until done, until it drops its request, or until it has held
// the path for TIMEOUT cycles. All outputs are registered so the select is
// glitch-free for the whole grant.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
)(
  input  logic             clk,
  input  logic             rst_n,
  rr_sel_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gv_q, gv_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  sel_t             pick_idx;
  logic             rel_done, rel_drop, rel_to;

  rr_priority_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[sel_q];
  assign rel_to   = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Arbitrate in IDLE, hold and watch the three release causes in GRANT.
  // sel is deliberately left alone on release so the mux never sees a
  // spurious select change between grants.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    gv_d    = gv_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick_idx;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          gv_d    = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_to) begin
          gnt_d   = '0;
          gv_d    = 1'b0;
          ptr_d   = sel_t'(sel_q + sel_t'(1));
          cnt_d   = '0;
          to_d    = rel_to & ~rel_done & ~rel_drop;
          state_d = IDLE;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, hold counter and output registers; reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel          = sel_q;
  assign bus.gnt          = gnt_q;
  assign bus.gnt_valid    = gv_q;
  assign bus.timeout_flag = to_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: reset, single grant, fairness rotation,
// hold timeout, pointer wrap, release priority and asynchronous reset.
module tb_rr_sel_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rr_sel_arbiter_if bus ();

  rr_sel_arbiter #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs at a falling edge and let exactly one rising edge see them.
  task automatic applyStimulus(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_sel,
                             input logic [3:0] exp_gnt, input logic exp_gv,
                             input logic exp_to);
    vectors++;
    assert (bus.sel === exp_sel) else begin
      miscompares++;
      $error("[TB] FAIL %s sel: observed %b expected %b", tag, bus.sel, exp_sel);
    end
    vectors++;
    assert (bus.gnt === exp_gnt) else begin
      miscompares++;
      $error("[TB] FAIL %s gnt: observed %b expected %b", tag, bus.gnt, exp_gnt);
    end
    vectors++;
    assert (bus.gnt_valid === exp_gv) else begin
      miscompares++;
      $error("[TB] FAIL %s gnt_valid: observed %b expected %b", tag, bus.gnt_valid, exp_gv);
    end
    vectors++;
    assert (bus.timeout_flag === exp_to) else begin
      miscompares++;
      $error("[TB] FAIL %s timeout_flag: observed %b expected %b", tag, bus.timeout_flag, exp_to);
    end
  endtask

  initial begin
    logic [1:0] s;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.done    = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single request on source 2, then withdraw it: ptr becomes 3
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_grant", 2'b10, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_drop", 2'b10, 4'b0000, 1'b0, 1'b0);

    // All requesting, done after each grant: order 3,0,1,2,3,0 with bubbles
    for (int k = 0; k < 6; k++) begin
      s = 2'(3 + k);
      applyStimulus(4'b1111, 1'b0);
      checkOutput($sformatf("fair_grant%0d", k), s, 4'b0001 << s, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("fair_bubble%0d", k), s, 4'b0000, 1'b0, 1'b0);
    end
    // ptr is now 1 and the FSM is idle

    // Source 1 held with no done: 15 grant cycles then a timeout pulse
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_grant", 2'b01, 4'b0010, 1'b1, 1'b0);
    for (int k = 1; k < 15; k++) begin
      applyStimulus(4'b0010, 1'b0);
      checkOutput($sformatf("to_hold%0d", k), 2'b01, 4'b0010, 1'b1, 1'b0);
    end
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_release", 2'b01, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_regrant", 2'b01, 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_drop", 2'b01, 4'b0000, 1'b0, 1'b0);
    // ptr is now 2

    // Pointer wrap: 1001 from ptr 2 grants 3, then 0
    applyStimulus(4'b1001, 1'b0);
    checkOutput("wrap_grant3", 2'b11, 4'b1000, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_release", 2'b11, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("wrap_grant0", 2'b00, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("wrap_drop", 2'b00, 4'b0000, 1'b0, 1'b0);
    // ptr is now 1

    // done arriving on the timeout cycle suppresses timeout_flag
    applyStimulus(4'b0100, 1'b0);
    checkOutput("both_grant", 2'b10, 4'b0100, 1'b1, 1'b0);
    for (int k = 1; k < 15; k++) applyStimulus(4'b0100, 1'b0);
    checkOutput("both_last", 2'b10, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("both_release", 2'b10, 4'b0000, 1'b0, 1'b0);

    // done while idle does nothing
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_done", 2'b10, 4'b0000, 1'b0, 1'b0);
    // ptr is now 3

    // Reset in the middle of a grant to source 3 clears outputs immediately
    applyStimulus(4'b1000, 1'b0);
    checkOutput("rst_pre", 2'b11, 4'b1000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 2'b00, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("rst_first", 2'b00, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("rst_second", 2'b01, 4'b0010, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
